seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter DWELL_CYCLES, default 50000: clocks each digit is lit, ≥1.
REQ-003 SHALL have parameter GUARD_CYCLES, default 500: all-off clocks between digits (anti-ghosting), ≥1.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  1 = scanning; 0 = display dark.
REQ-007 load  in  1  one-cycle strobe; captures value/dp_mask/lz_en into pending register.
REQ-008 value  in  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit.
REQ-009 dp_mask  in  NUM_DIGITS  1 = decimal point lit on that digit.
REQ-010 lz_en  in  1  1 = leading-zero blanking.
REQ-011 load_ack  out  1  one-cycle pulse: pending data committed to display.
REQ-012 an  out  NUM_DIGITS  digit enables, active-low.
REQ-013 seg  out  8  segments, active-low; seg[7] = dp, seg[6:0] = g..a.

Function
REQ-014 FSM states: GUARD (all an=1, seg=8'hFF), SHOW (an[idx]=0, rest 1).
REQ-015 GUARD: counter runs 0..GUARD_CYCLES-1, then -> SHOW, counter cleared.
REQ-016 SHOW: counter runs 0..DWELL_CYCLES-1, then -> GUARD, counter cleared, idx advances.
REQ-017 idx wraps NUM_DIGITS-1 -> 0; the SHOW->GUARD edge of digit NUM_DIGITS-1 is the frame boundary.
REQ-018 load captures into pending register and sets pending flag; a later load before commit overwrites it.
REQ-019 At frame boundary with pending flag set: pending copied to active register, flag cleared, load_ack=1 the following cycle.
REQ-020 load coinciding with frame boundary: incoming data committed directly; load_ack the following cycle.
REQ-021 Display reads only the active register; no mid-frame change (tear-free).
REQ-022 seg[6:0] = hex decode of active nibble idx; seg[7] = ~dp_mask_active[idx].
REQ-023 lz_en_active=1: digit k>0 shows seg=8'hFF and an[k]=1 if nibbles k..NUM_DIGITS-1 all zero; digit 0 never blanked; dp still suppressed on blanked digits.
REQ-024 an and seg registered: reflect FSM state/idx with one clock latency.
REQ-025 enable=0: next edge forces GUARD, counter 0, idx 0; an all 1, seg 8'hFF; load/commit logic keeps operating, commit occurring on enable re-assertion's first frame boundary.
REQ-026 enable rising: scan starts at GUARD, idx 0.

Reset
REQ-027 rst_n=0 asynchronously: state GUARD, counter 0, idx 0, pending flag 0, pending and active registers 0, load_ack 0, an all 1, seg 8'hFF.
REQ-028 Reset mid-frame discards pending data with no load_ack.

Structure
REQ-029 Shared package seven_seg_pkg SHALL hold the state enum, SEG_OFF=8'hFF, AN_OFF (all ones) constant function.
REQ-030 Hex decode SHALL instantiate the existing valueToSevenSeg decoder (one instance, muxed nibble input); dp handled in this block.
REQ-031 Counter width = clog2(max(DWELL_CYCLES,GUARD_CYCLES)).

Verification (NUM_DIGITS=4, DWELL=4, GUARD=2)
REQ-032 Reset release, enable=1, value=16'h0000 -> an sequence 1111x2, 1110x4, 1111x2, 1101x4, ... wraps after 1111_0111; seg=8'hC0 while lit.
REQ-033 load value=16'h12AF, dp_mask=4'b0010 mid-frame -> old data until boundary; load_ack one pulse; then digit0 seg=8'h8E, digit1 seg=8'h08 (dp on).
REQ-034 lz_en=1, value=16'h0050 -> digits 3,2 dark (an bit stays 1), digit1 8'h92, digit0 8'hC0; value=16'h0000 -> only digit0 lit 8'hC0.
REQ-035 Two loads before boundary (16'h1111 then 16'h2222) -> single load_ack, display 2222; load exactly on boundary -> committed same frame.
REQ-036 enable dropped during SHOW of digit 2 -> next cycle all dark; re-enable -> restarts GUARD, digit 0.
REQ-037 rst_n asserted with pending load -> outputs off immediately (asynchronous), no load_ack, active value 0 after release.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared scan-state encoding and display-off constants.
// Revision : 1.0
// ============================================================================
package seven_seg_pkg;

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // All-ones anode pattern for n digits, right-aligned in an 8-bit word.
  function automatic logic [7:0] AN_OFF(input int n);
    return 8'hFF >> (8 - n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : valueToSevenSeg
// Purpose  : Hex nibble to active-low seven-segment pattern (g..a).
// Revision : 1.0
// ============================================================================
module valueToSevenSeg (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Purpose  : Multiplexed seven-segment scanner with guard gaps, leading-zero
//            blanking and frame-synchronous (tear-free) data commit.
// Revision : 1.0
// ============================================================================
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_en,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      C_DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]      C_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0]      C_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] C_AN_OFF     = NUM_DIGITS'(AN_OFF(NUM_DIGITS));

  scan_state_t             r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_seg;

  logic [4*NUM_DIGITS-1:0] r_val_pend;
  logic [NUM_DIGITS-1:0]   r_dp_pend;
  logic                    r_lz_pend;
  logic                    r_pend;
  logic [4*NUM_DIGITS-1:0] r_val_act;
  logic [NUM_DIGITS-1:0]   r_dp_act;
  logic                    r_lz_act;
  logic                    r_ack;

  logic [NUM_DIGITS-1:0]   w_zero_from;
  logic [3:0]              w_nibble;
  logic [6:0]              w_dec;
  logic                    w_blank;
  logic                    w_boundary;
  logic [NUM_DIGITS-1:0]   w_an_show;
  logic [7:0]              w_seg_show;

  // w_zero_from[k]: every nibble from digit k up to the leftmost is zero.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
    assign w_zero_from[k] = (r_val_act[4*NUM_DIGITS-1:4*k] == '0);
  end

  assign w_nibble   = r_val_act[{r_idx, 2'b00} +: 4];
  assign w_blank    = r_lz_act && (r_idx != '0) && w_zero_from[r_idx];
  assign w_an_show  = w_blank ? C_AN_OFF : ~(NUM_DIGITS'(1) << r_idx);
  assign w_seg_show = w_blank ? SEG_OFF : {~r_dp_act[r_idx], w_dec};
  assign w_boundary = enable && (r_state == ST_SHOW) && (r_cnt == C_DWELL_LAST) &&
                      (r_idx == C_IDX_LAST);

  valueToSevenSeg u_dec (
    .value (w_nibble),
    .seg   (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_an    <= C_AN_OFF;
      r_seg   <= SEG_OFF;
    end else if (!enable) begin
      r_state <= ST_GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_an    <= C_AN_OFF;
      r_seg   <= SEG_OFF;
    end else begin
      case (r_state)
        ST_GUARD: begin
          r_an  <= C_AN_OFF;
          r_seg <= SEG_OFF;
          if (r_cnt == C_GUARD_LAST) begin
            r_state <= ST_SHOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          r_an  <= w_an_show;
          r_seg <= w_seg_show;
          if (r_cnt == C_DWELL_LAST) begin
            r_state <= ST_GUARD;
            r_cnt   <= '0;
            r_idx   <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_GUARD;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_an    <= C_AN_OFF;
          r_seg   <= SEG_OFF;
        end
      endcase
    end
  end

  // A load on the boundary edge bypasses the pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val_pend <= '0;
      r_dp_pend  <= '0;
      r_lz_pend  <= 1'b0;
      r_pend     <= 1'b0;
      r_val_act  <= '0;
      r_dp_act   <= '0;
      r_lz_act   <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (w_boundary && load) begin
        r_val_act <= value;
        r_dp_act  <= dp_mask;
        r_lz_act  <= lz_en;
        r_pend    <= 1'b0;
        r_ack     <= 1'b1;
      end else if (w_boundary && r_pend) begin
        r_val_act <= r_val_pend;
        r_dp_act  <= r_dp_pend;
        r_lz_act  <= r_lz_pend;
        r_pend    <= 1'b0;
        r_ack     <= 1'b1;
      end else if (load) begin
        r_val_pend <= value;
        r_dp_pend  <= dp_mask;
        r_lz_pend  <= lz_en;
        r_pend     <= 1'b1;
      end
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign load_ack = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Purpose  : Directed self-checking bench, NUM_DIGITS=4, DWELL=4, GUARD=2.
// Revision : 1.0
// ============================================================================
module tb_seven_seg_scan_ctrl;

  localparam int N = 4, D = 4, G = 2, SLOT = D + G, FRAME = N * SLOT;

  logic        clk, rst_n, enable, load, lz_en, load_ack;
  logic [15:0] value;
  logic [3:0]  dp_mask, an;
  logic [7:0]  seg;
  int          checks = 0, errors = 0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_mask(dp_mask), .lz_en(lz_en), .load_ack(load_ack), .an(an), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // p = sample index after the p+1-th edge of a frame that starts in GUARD/idx0.
  function automatic logic [3:0] exp_an(int p, logic [3:0] lit);
    int d = p / SLOT;
    if ((p % SLOT) < G || !lit[d]) return 4'hF;
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [7:0] exp_seg(int p, logic [31:0] segs, logic [3:0] lit);
    int d = p / SLOT;
    if ((p % SLOT) < G || !lit[d]) return 8'hFF;
    return segs[d*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; load = 1'b0; value = '0; dp_mask = '0; lz_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want f", an); end
      checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", seg); end
      checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", load_ack); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    for (int p = 0; p < FRAME; p++) begin
      tick();
      checks++; if (an !== exp_an(p, 4'hF))
        begin errors++; $display("FAIL scan_an p%0d: got %h want %h", p, an, exp_an(p, 4'hF)); end
      checks++; if (seg !== exp_seg(p, 32'hC0C0C0C0, 4'hF))
        begin errors++; $display("FAIL scan_seg p%0d: got %h want %h", p, seg, exp_seg(p, 32'hC0C0C0C0, 4'hF)); end
      checks++; if (load_ack !== 1'b0)
        begin errors++; $display("FAIL scan_ack p%0d: got %b want 0", p, load_ack); end
    end
  endtask

  task automatic test_load_mid();
    logic [31:0] segs [2] = '{32'hC0C0C0C0, 32'hF9A4088E};
    logic        ack  [2] = '{1'b1, 1'b0};
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < FRAME; p++) begin
        load = (f == 0 && p == 8);
        if (load) begin value = 16'h12AF; dp_mask = 4'b0010; lz_en = 1'b0; end
        tick();
        checks++; if (an !== exp_an(p, 4'hF))
          begin errors++; $display("FAIL load_an f%0d p%0d: got %h want %h", f, p, an, exp_an(p, 4'hF)); end
        checks++; if (seg !== exp_seg(p, segs[f], 4'hF))
          begin errors++; $display("FAIL load_seg f%0d p%0d: got %h want %h", f, p, seg, exp_seg(p, segs[f], 4'hF)); end
        checks++; if (load_ack !== (ack[f] && p == FRAME-1))
          begin errors++; $display("FAIL load_ack f%0d p%0d: got %b want %b", f, p, load_ack, ack[f] && p == FRAME-1); end
      end
    load = 1'b0;
  endtask

  task automatic test_lz();
    logic [31:0] segs [3] = '{32'hF9A4088E, 32'hFFFF92C0, 32'hFFFFFFC0};
    logic [3:0]  lit  [3] = '{4'b1111, 4'b0011, 4'b0001};
    logic        ack  [3] = '{1'b1, 1'b1, 1'b0};
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < FRAME; p++) begin
        load = (f == 0 && p == 3) || (f == 1 && p == 5);
        if (load) begin value = (f == 0) ? 16'h0050 : 16'h0000; dp_mask = 4'b0000; lz_en = 1'b1; end
        tick();
        checks++; if (an !== exp_an(p, lit[f]))
          begin errors++; $display("FAIL lz_an f%0d p%0d: got %h want %h", f, p, an, exp_an(p, lit[f])); end
        checks++; if (seg !== exp_seg(p, segs[f], lit[f]))
          begin errors++; $display("FAIL lz_seg f%0d p%0d: got %h want %h", f, p, seg, exp_seg(p, segs[f], lit[f])); end
        checks++; if (load_ack !== (ack[f] && p == FRAME-1))
          begin errors++; $display("FAIL lz_ack f%0d p%0d: got %b want %b", f, p, load_ack, ack[f] && p == FRAME-1); end
      end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] segs [3] = '{32'hFFFFFFC0, 32'hA4A4A4A4, 32'hB0B0B0B0};
    logic [3:0]  lit  [3] = '{4'b0001, 4'b1111, 4'b1111};
    logic        ack  [3] = '{1'b1, 1'b1, 1'b0};
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < FRAME; p++) begin
        load = 1'b0; dp_mask = 4'b0000; lz_en = 1'b0;
        if (f == 0 && p == 4)       begin load = 1'b1; value = 16'h1111; end
        if (f == 0 && p == 10)      begin load = 1'b1; value = 16'h2222; end
        if (f == 1 && p == FRAME-1) begin load = 1'b1; value = 16'h3333; end
        tick();
        checks++; if (an !== exp_an(p, lit[f]))
          begin errors++; $display("FAIL b2b_an f%0d p%0d: got %h want %h", f, p, an, exp_an(p, lit[f])); end
        checks++; if (seg !== exp_seg(p, segs[f], lit[f]))
          begin errors++; $display("FAIL b2b_seg f%0d p%0d: got %h want %h", f, p, seg, exp_seg(p, segs[f], lit[f])); end
        checks++; if (load_ack !== (ack[f] && p == FRAME-1))
          begin errors++; $display("FAIL b2b_ack f%0d p%0d: got %b want %b", f, p, load_ack, ack[f] && p == FRAME-1); end
      end
    load = 1'b0;
  endtask

  task automatic test_enable();
    logic [31:0] segs [3] = '{32'hB0B0B0B0, 32'hB0B0B0B0, 32'h99999999};
    logic        ack  [3] = '{1'b0, 1'b1, 1'b0};
    for (int f = 0; f < 3; f++) begin
      enable = 1'b1;
      for (int p = 0; p < FRAME; p++) begin
        if (f == 0 && p == 15) break;
        tick();
        checks++; if (an !== exp_an(p, 4'hF))
          begin errors++; $display("FAIL en_an f%0d p%0d: got %h want %h", f, p, an, exp_an(p, 4'hF)); end
        checks++; if (seg !== exp_seg(p, segs[f], 4'hF))
          begin errors++; $display("FAIL en_seg f%0d p%0d: got %h want %h", f, p, seg, exp_seg(p, segs[f], 4'hF)); end
        checks++; if (load_ack !== (ack[f] && p == FRAME-1))
          begin errors++; $display("FAIL en_ack f%0d p%0d: got %b want %b", f, p, load_ack, ack[f] && p == FRAME-1); end
      end
      if (f == 0) begin
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
          load = (i == 1);
          if (load) begin value = 16'h4444; dp_mask = 4'b0000; lz_en = 1'b0; end
          tick();
          checks++; if (an !== 4'hF) begin errors++; $display("FAIL dis_an i%0d: got %h want f", i, an); end
          checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL dis_seg i%0d: got %h want ff", i, seg); end
          checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL dis_ack i%0d: got %b want 0", i, load_ack); end
        end
        load = 1'b0;
      end
    end
  endtask

  task automatic test_reset_pending();
    for (int p = 0; p < 10; p++) begin
      load = (p == 5);
      if (load) begin value = 16'h5555; dp_mask = 4'b1111; lz_en = 1'b0; end
      tick();
    end
    load = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL arst_an: got %h want f", an); end
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL arst_seg: got %h want ff", seg); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL arst_ack: got %b want 0", load_ack); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < FRAME; p++) begin
      tick();
      checks++; if (an !== exp_an(p, 4'hF))
        begin errors++; $display("FAIL rst_an p%0d: got %h want %h", p, an, exp_an(p, 4'hF)); end
      checks++; if (seg !== exp_seg(p, 32'hC0C0C0C0, 4'hF))
        begin errors++; $display("FAIL rst_seg p%0d: got %h want %h", p, seg, exp_seg(p, 32'hC0C0C0C0, 4'hF)); end
      checks++; if (load_ack !== 1'b0)
        begin errors++; $display("FAIL rst_ack p%0d: got %b want 0", p, load_ack); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_mid();
    test_lz();
    test_back_to_back();
    test_enable();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
